// File: rtl/dmem_responder_pkg.sv
// Shared word width and FSM state encoding for the data-memory responder.
// Imported by the top level and the storage array.
package dmem_responder_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word array with a per-byte write mask on the clock edge and an asynchronous read.
// Contents are deliberately left uninitialised by reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [AW-1:0]         idx_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, held response.
// The array access happens on the edge that enters RESP; the response waits for resp_ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_LOAD = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [31:0]           addr_q;
  logic                  write_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  resp_valid_q;
  logic [WORD_WIDTH-1:0] resp_rdata_q;
  logic                  resp_err_q;

  logic                  accept;
  logic                  commit;
  logic [31:0]           cmd_addr;
  logic                  cmd_write;
  logic [WORD_WIDTH-1:0] cmd_wdata;
  logic [3:0]            cmd_be;
  logic [31:0]           offset;
  logic                  cmd_err;
  logic [AW-1:0]         idx;
  logic [WORD_WIDTH-1:0] arr_rdata;
  logic [WORD_WIDTH-1:0] resp_rdata_d;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With LATENCY == 1 the commit edge is the accepting edge, so use the live request.
  always_comb begin
    cmd_addr  = addr_q;
    cmd_write = write_q;
    cmd_wdata = wdata_q;
    cmd_be    = be_q;
    if (state_q == IDLE) begin
      cmd_addr  = req_addr;
      cmd_write = req_write;
      cmd_wdata = req_wdata;
      cmd_be    = req_be;
    end
  end

  assign offset  = cmd_addr - ADDR_BASE;
  assign cmd_err = (offset[1:0] != 2'b00) || (offset >= SPAN);
  assign idx     = offset[AW+1:2];
  assign commit  = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd0));

  assign resp_rdata_d = (cmd_write || cmd_err) ? '0 : arr_rdata;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (commit && cmd_write && !cmd_err),
    .be_i    (cmd_be),
    .idx_i   (idx),
    .wdata_i (cmd_wdata),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= resp_rdata_d;
              resp_err_q   <= cmd_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= cmd_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has LATENCY 2, instance 1 has LATENCY 4.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_BASE(32'h0)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .ADDR_BASE(32'h0)) u_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  typedef struct {
    int          dut;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction; resp_ready is held low for 'hold' cycles in RESP.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, input logic [31:0] exp_rd,
                     input logic exp_err, input string name);
    int n;
    int lat;
    lat = (d == 0) ? 2 : 4;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    resp_ready[d] = (hold == 0);
    chk({name, " ready"}, {31'd0, req_ready[d]}, 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, lat);
    chk({name, " rdata"}, resp_rdata[d], exp_rd);
    chk({name, " err"}, {31'd0, resp_err[d]}, {31'd0, exp_err});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({name, " hold valid"}, {31'd0, resp_valid[d]}, 32'd1);
      chk({name, " hold rdata"}, resp_rdata[d], exp_rd);
      chk({name, " hold ready"}, {31'd0, req_ready[d]}, 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    chk({name, " done valid"}, {31'd0, resp_valid[d]}, 32'd0);
    chk({name, " done rdata"}, resp_rdata[d], 32'd0);
    chk({name, " done ready"}, {31'd0, req_ready[d]}, 32'd1);
  endtask

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0},
      '{0, 1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0},
      '{0, 1'b1, 32'h10,  32'h11223344, 4'h5, 0, 32'h0,        1'b0},
      '{0, 1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDE22BE44, 1'b0},
      '{0, 1'b0, 32'h12,  32'h0,        4'h0, 0, 32'h0,        1'b1},
      '{0, 1'b1, 32'h0,   32'h55AA55AA, 4'hF, 0, 32'h0,        1'b0},
      '{0, 1'b1, 32'h1000,32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1},
      '{0, 1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h55AA55AA, 1'b0},
      '{0, 1'b1, 32'h14,  32'hA5A5A5A5, 4'hF, 0, 32'h0,        1'b0},
      '{0, 1'b1, 32'h14,  32'h12345678, 4'h0, 0, 32'h0,        1'b0},
      '{0, 1'b0, 32'h14,  32'h0,        4'h0, 0, 32'hA5A5A5A5, 1'b0},
      '{0, 1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, 0, 32'h0,        1'b0},
      '{0, 1'b0, 32'hFFC, 32'h0,        4'h0, 0, 32'h0BADCAFE, 1'b0},
      '{0, 1'b0, 32'h10,  32'h0,        4'h0, 5, 32'hDE22BE44, 1'b0},
      '{1, 1'b1, 32'h20,  32'h600DF00D, 4'hF, 0, 32'h0,        1'b0},
      '{1, 1'b0, 32'h20,  32'h0,        4'h0, 0, 32'h600DF00D, 1'b0}
    };

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 32'h0;
      req_wdata[d] = 32'hFFFF_FFFF; req_be[d] = 4'hF; resp_ready[d] = 1'b1;
    end

    // Reset held two cycles with a request pending: nothing may be accepted.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("reset ready", {31'd0, req_ready[0]}, 32'd1);
      chk("reset valid", {31'd0, resp_valid[0]}, 32'd0);
      chk("reset rdata", resp_rdata[0], 32'd0);
      chk("reset err", {31'd0, resp_err[0]}, 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0;
    end
    @(posedge clk); #1;
    chk("post reset ready", {31'd0, req_ready[0]}, 32'd1);
    chk("post reset l4 ready", {31'd0, req_ready[1]}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].dut, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset during WAIT abandons an uncommitted write on the LATENCY 4 instance.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'hCAFEF00D; req_be[1] = 4'hF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("midrst accepted", {31'd0, req_ready[1]}, 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midrst ready", {31'd0, req_ready[1]}, 32'd1);
    chk("midrst valid", {31'd0, resp_valid[1]}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst quiet", {31'd0, resp_valid[1]}, 32'd0);
    end
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h600DF00D, 1'b0, "midrst readback");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
